// File: rtl/gate_arb_pkg.sv
// Shared definitions for gate_rr_arbiter: opcode encoding and the bitwise
// evaluation function used by the shared logic unit.
package gate_arb_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_AND  = 2'b00;
   localparam op_t OP_OR   = 2'b01;
   localparam op_t OP_XOR  = 2'b10;
   localparam op_t OP_NAND = 2'b11;

   // Widest operand the evaluator handles; callers cast in and truncate out.
   localparam int GATE_W_MAX = 64;

   function automatic logic [GATE_W_MAX-1:0] gate_eval(
      input op_t                   op,
      input logic [GATE_W_MAX-1:0] a,
      input logic [GATE_W_MAX-1:0] b
   );
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NAND: return ~(a & b);
      endcase
   endfunction

endpackage

// File: rtl/gate_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first asserted request found
// scanning upward from ptr+1, wrapping modulo NUM_REQ.
module rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic [ID_W-1:0]    gnt_idx
);

   int   idx;
   logic found;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the loop can leave a value unassigned and infer a latch.
   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      found      = 1'b0;
      idx        = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found           = 1'b1;
            gnt_onehot[idx] = 1'b1;
            gnt_idx         = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/gate_rr_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit among NUM_REQ requesters.
// Optional stall counter output enabled by GATE_ARB_STALL_CNT_EN.
module gate_rr_arbiter
   import gate_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int WIDTH   = 8,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [2*NUM_REQ-1:0]     req_op,
   input  logic [WIDTH*NUM_REQ-1:0] req_a,
   input  logic [WIDTH*NUM_REQ-1:0] req_b,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res_data,
   output logic [ID_W-1:0]          res_id
`ifdef GATE_ARB_STALL_CNT_EN
   ,
   output logic [15:0]              stall_cnt
`endif
);

   logic [ID_W-1:0]    rr_ptr;
   logic [NUM_REQ-1:0] gnt_onehot;
   logic [ID_W-1:0]    gnt_idx;
   logic               can_accept;
   logic               transfer;
   op_t                gnt_op;
   logic [WIDTH-1:0]   gnt_a;
   logic [WIDTH-1:0]   gnt_b;
   logic [WIDTH-1:0]   res_next;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req        (req_valid),
      .ptr        (rr_ptr),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx)
   );

   // Ready is withheld during reset even though rr_ptr already holds its reset value.
   assign can_accept = !res_valid || res_ready;
   assign req_ready  = (rst_n && can_accept) ? gnt_onehot : '0;
   assign transfer   = |(req_valid & req_ready);

   assign gnt_op   = op_t'(req_op[2*int'(gnt_idx) +: 2]);
   assign gnt_a    = req_a[WIDTH*int'(gnt_idx) +: WIDTH];
   assign gnt_b    = req_b[WIDTH*int'(gnt_idx) +: WIDTH];
   assign res_next = WIDTH'(gate_eval(gnt_op, GATE_W_MAX'(gnt_a), GATE_W_MAX'(gnt_b)));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
         rr_ptr    <= ID_W'(NUM_REQ - 1);
      end else if (transfer) begin
         res_valid <= 1'b1;
         res_data  <= res_next;
         res_id    <= gnt_idx;
         rr_ptr    <= gnt_idx;
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end

`ifdef GATE_ARB_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (res_valid && !res_ready && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
